move_cmd_queue: RTL and testbench
=================================

// Module: move_cmd_queue
// PURPOSE
//   Receiving end of the per-key move pulses: collects the one-cycle pulses from the
//   four key repeat/limiter instances (left, right, rotate, drop) and serialises them
//   into a small command FIFO. The FIFO is drained by the game engine through a
//   valid/ready handshake. Simultaneous pulses are ordered by fixed priority, and none
//   is lost unless the same key fires again while its earlier request is still waiting.
// PARAMETERS
//   DEPTH   4   FIFO entries; must be a power of two and >= 2
//   PTR_W   2   log2(DEPTH); width of the FIFO read/write pointers
// PORTS
//   clk         in   1        system clock; all logic updates on posedge
//   RST         in   1        synchronous reset, active-high
//   move_pulse  in   4        one-cycle request pulses: [0]=left [1]=right [2]=rotate [3]=drop
//   cmd_valid   out  1        FIFO head holds a command
//   cmd_code    out  2        head command: 00=left 01=right 10=rotate 11=drop
//   cmd_ready   in   1        engine accepts the head this cycle (pop when cmd_valid)
//   fifo_count  out  PTR_W+1  number of FIFO entries, 0..DEPTH
//   drop_flag   out  1        sticky: a request was coalesced/lost since reset
// BEHAVIOUR
//   Reset (RST=1 at a posedge): pend=0000, rd_ptr=wr_ptr=0, fifo_count=0, drop_flag=0;
//     hence cmd_valid=0 and cmd_code=00. Reset mid-operation discards pending and queued commands.
//   Pending stage (4 flops, one per key):
//     pend[i] <= (pend[i] & ~grant[i]) | move_pulse[i]
//     - pulse on a key not pending: pend set next cycle
//     - pulse in the same cycle as that key's grant: pend stays 1 (new request kept)
//     - pulse while pend[i]=1 and not granted: coalesced; drop_flag <= 1
//   Grant: at most one per cycle, to the highest set pend bit, priority 3 > 2 > 1 > 0.
//     Issued only if space: fifo_count < DEPTH, or fifo_count == DEPTH and pop this cycle.
//     The granted key's code (= its bit index) is written to mem[wr_ptr].
//   FIFO: push = grant issued; pop = cmd_valid & cmd_ready.
//     cmd_valid = (fifo_count != 0); cmd_code = mem[rd_ptr] (registered storage, comb read)
//     push & pop in the same cycle: count unchanged, both pointers advance (legal when full)
//     pop while empty: ignored. Pointers wrap modulo DEPTH.
//     fifo_count is never > DEPTH and never < 0.
//   Latency: pulse at edge N is in pend after N, pushed at N+1, cmd_valid=1 after N+1,
//     i.e. 2 cycles pulse-to-valid into an empty FIFO with no higher-priority pending key.
//   Order: FIFO order = grant order. Keys pending simultaneously are queued highest bit first.
//   drop_flag: cleared only by RST; set by coalescing as above. A FIFO-full stall alone
//     does not set it; the request waits in pend.
// TESTING
//   1 reset, then move_pulse=0001 one cycle -> 2 cycles later cmd_valid=1, cmd_code=00;
//     cmd_ready=1 one cycle -> cmd_valid=0, fifo_count=0
//   2 move_pulse=1111 one cycle, cmd_ready=0 -> FIFO fills over 4 cycles with codes
//     11,10,01,00 in that order; fifo_count=4; drop_flag=0
//   3 FIFO full (4 entries), pulse [2] twice, 3 cycles apart, cmd_ready=0 -> second pulse
//     sets drop_flag=1; after popping one entry, exactly one 10 is pushed
//   4 FIFO full, pend[0]=1, cmd_ready=1 for one cycle -> same-cycle pop and push,
//     fifo_count stays 4, tail code=00, head advances
//   5 pulse [1] in the same cycle its pending request is granted -> two 01 entries
//     queued, drop_flag=0
//   6 RST asserted with 3 queued entries and pend=0101 -> next cycle cmd_valid=0,
//     fifo_count=0, drop_flag=0, no later pushes

Source files
------------

// File: rtl/move_cmd_queue_if.sv
// Command handshake between the move queue and the game engine.
// master = queue side (drives the head command), slave = engine side.
interface move_cmd_queue_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );
endinterface

// File: rtl/move_cmd_queue.sv
// Collects per-key move pulses, arbitrates them by fixed priority
// and serialises them into a small command FIFO for the engine.
module move_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [3:0]       move_pulse,
  move_cmd_queue_if.master cmd,
  output logic [PTR_W:0]   fifo_count,
  output logic             drop_flag
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

  logic [3:0]       pend;
  logic [3:0]       grant;
  logic [1:0]       gcode;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [1:0]       mem [DEPTH];
  logic             pop;
  logic             push;
  logic             space;
  logic             coalesce;

  assign cmd.cmd_valid = (fifo_count != '0);
  assign cmd.cmd_code  = mem[rd_ptr];

  assign pop   = cmd.cmd_valid & cmd.cmd_ready;
  assign space = (fifo_count != FULL) | pop;

  always_comb begin
    grant = '0;
    gcode = 2'd0;
    if (space) begin
      priority case (1'b1)
        pend[3]: begin grant = 4'b1000; gcode = 2'd3; end
        pend[2]: begin grant = 4'b0100; gcode = 2'd2; end
        pend[1]: begin grant = 4'b0010; gcode = 2'd1; end
        pend[0]: begin grant = 4'b0001; gcode = 2'd0; end
        default: begin grant = '0;      gcode = 2'd0; end
      endcase
    end
  end

  assign push     = |grant;
  // A repeat pulse is only lost if its key is still waiting ungranted
  assign coalesce = |(move_pulse & pend & ~grant);

  always_ff @(posedge clk) begin
    if (RST) begin
      pend       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      drop_flag  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
    end else begin
      pend <= (pend & ~grant) | move_pulse;
      if (coalesce) drop_flag <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= gcode;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + ONE;
        2'b01:   fifo_count <= fifo_count - ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench: expected codes queued at stimulus time,
// a negedge monitor pops and compares on every engine accept.
module tb_move_cmd_queue;

  logic       clk;
  logic       RST;
  logic [3:0] move_pulse;
  logic [2:0] fifo_count;
  logic       drop_flag;

  int errors;
  int checks;
  logic [1:0] sb [$];

  move_cmd_queue_if cmd ();

  move_cmd_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .RST        (RST),
    .move_pulse (move_pulse),
    .cmd        (cmd.master),
    .fifo_count (fifo_count),
    .drop_flag  (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!RST && cmd.cmd_valid && cmd.cmd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got code %0d expected none",
                 cmd.cmd_code);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if (cmd.cmd_code !== e) begin
          errors++;
          $display("FAIL pop_code: got %0d expected %0d", cmd.cmd_code, e);
        end
      end
    end
  end

  task automatic drain(input int n);
    cmd.cmd_ready = 1'b1;
    repeat (n) tick();
    cmd.cmd_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    move_pulse = 4'b0000;
    cmd.cmd_ready = 1'b0;
    RST = 1'b1;
    tick();
    do_reset();

    // reset state
    check("rst_valid", 32'(cmd.cmd_valid), 0);
    check("rst_code", 32'(cmd.cmd_code), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_drop", 32'(drop_flag), 0);

    // single left pulse: two cycles to valid
    move_pulse = 4'b0001;
    tick();
    move_pulse = 4'b0000;
    check("t1_lat_valid", 32'(cmd.cmd_valid), 0);
    sb.push_back(2'd0);
    tick();
    check("t1_valid", 32'(cmd.cmd_valid), 1);
    check("t1_code", 32'(cmd.cmd_code), 0);
    drain(1);
    check("t1_empty_valid", 32'(cmd.cmd_valid), 0);
    check("t1_empty_count", 32'(fifo_count), 0);

    // all four keys at once: priority order 3,2,1,0
    move_pulse = 4'b1111;
    tick();
    move_pulse = 4'b0000;
    sb.push_back(2'd3);
    sb.push_back(2'd2);
    sb.push_back(2'd1);
    sb.push_back(2'd0);
    repeat (2) tick();
    check("t2_partial_count", 32'(fifo_count), 2);
    repeat (2) tick();
    check("t2_count", 32'(fifo_count), 4);
    check("t2_drop", 32'(drop_flag), 0);
    check("t2_head", 32'(cmd.cmd_code), 3);

    // full FIFO, rotate pulsed twice: second one coalesced
    move_pulse = 4'b0100;
    tick();
    move_pulse = 4'b0000;
    check("t3_no_drop_yet", 32'(drop_flag), 0);
    repeat (2) tick();
    move_pulse = 4'b0100;
    tick();
    move_pulse = 4'b0000;
    check("t3_drop", 32'(drop_flag), 1);
    check("t3_stall_count", 32'(fifo_count), 4);
    sb.push_back(2'd2);
    drain(1);
    check("t3_refill_count", 32'(fifo_count), 4);
    tick();
    check("t3_single_push", 32'(fifo_count), 4);

    // full FIFO with left pending: pop and push in one cycle
    move_pulse = 4'b0001;
    tick();
    move_pulse = 4'b0000;
    tick();
    check("t4_wait_count", 32'(fifo_count), 4);
    sb.push_back(2'd0);
    drain(1);
    check("t4_count", 32'(fifo_count), 4);
    check("t4_head", 32'(cmd.cmd_code), 1);
    drain(4);
    check("t4_drained", 32'(fifo_count), 0);
    check("t4_drained_valid", 32'(cmd.cmd_valid), 0);

    // re-pulse during grant keeps the new request
    do_reset();
    check("t5_rst_drop", 32'(drop_flag), 0);
    move_pulse = 4'b0010;
    tick();
    tick();
    move_pulse = 4'b0000;
    sb.push_back(2'd1);
    sb.push_back(2'd1);
    tick();
    check("t5_count", 32'(fifo_count), 2);
    check("t5_drop", 32'(drop_flag), 0);
    tick();
    check("t5_no_extra", 32'(fifo_count), 2);
    drain(2);
    check("t5_drained", 32'(fifo_count), 0);

    // reset with 3 queued and pend=0101 discards everything
    move_pulse = 4'b0111;
    tick();
    move_pulse = 4'b0000;
    repeat (2) tick();
    move_pulse = 4'b0101;
    tick();
    move_pulse = 4'b0000;
    check("t6_pre_count", 32'(fifo_count), 3);
    check("t6_pre_drop", 32'(drop_flag), 0);
    do_reset();
    check("t6_valid", 32'(cmd.cmd_valid), 0);
    check("t6_count", 32'(fifo_count), 0);
    check("t6_drop", 32'(drop_flag), 0);
    repeat (4) tick();
    check("t6_no_push", 32'(fifo_count), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
